// File: rtl/adc_unpack_pkg.sv
// Shared types and constants for the ADC FIFO byte unpacker.
// Covers sample/word layout, the per-word mode encoding and the byte selection rules.
package adc_unpack_pkg;

    localparam int unsigned SAMPLE_W      = 12;
    localparam int unsigned WORD_W        = 2 * SAMPLE_W;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned IDX_W         = 2;
    localparam int unsigned LAST_IDX_FULL = 2;
    localparam int unsigned LAST_IDX_LOW  = 1;
    localparam int unsigned UF_W          = 8;
    localparam int unsigned UF_SAT        = 255;

    typedef enum logic [1:0] {
        FULL    = 2'd0,
        LOW_MSB = 2'd1,
        LOW_LSB = 2'd2
    } mode_e;

    typedef struct packed {
        logic [SAMPLE_W-1:0] s0;
        logic [SAMPLE_W-1:0] s1;
        mode_e               mode;
    } slot_t;

    function automatic mode_e mode_decode(input logic low_res, input logic low_res_lsb);
        if (!low_res)
            return FULL;
        return low_res_lsb ? LOW_LSB : LOW_MSB;
    endfunction

    function automatic logic [IDX_W-1:0] last_idx(input mode_e mode);
        return (mode == FULL) ? IDX_W'(LAST_IDX_FULL) : IDX_W'(LAST_IDX_LOW);
    endfunction

    // Byte presented for a given slot and byte index.
    function automatic logic [BYTE_W-1:0] byte_sel(input slot_t w, input logic [IDX_W-1:0] idx);
        logic [SAMPLE_W-1:0] s;
        s = (idx == IDX_W'(0)) ? w.s0 : w.s1;
        case (w.mode)
            FULL: begin
                case (idx)
                    IDX_W'(0): return w.s0[11:4];
                    IDX_W'(1): return {w.s0[3:0], w.s1[11:8]};
                    default:   return w.s1[7:0];
                endcase
            end
            LOW_LSB: return s[7:0];
            default: return s[11:4];
        endcase
    endfunction

endpackage

// File: rtl/adc_word_skid2.sv
// Two-slot prefetch buffer (HEAD/NEXT) for FIFO words with single in-flight read tracking.
// Exposes the next-cycle HEAD so the caller can register its byte output with no extra latency.
module adc_word_skid2 import adc_unpack_pkg::*; (
    input  logic              clk_usb,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_fifo_empty,
    input  logic [WORD_W-1:0] i_fifo_dout,
    input  mode_e             i_mode,
    input  logic              i_retire,
    output logic              o_rd_en_c,
    output slot_t             o_head,
    output slot_t             o_head_nxt_c,
    output logic              o_head_valid_nxt_c
);

    slot_t       r_head, r_next;
    logic        r_head_v, r_next_v, r_inflight;
    slot_t       w_head_n, w_next_n, w_word;
    logic        w_head_v_n, w_next_v_n;
    logic [1:0]  w_fill;

    assign w_fill    = 2'(r_head_v) + 2'(r_next_v) + 2'(r_inflight);
    assign o_rd_en_c = !i_fifo_empty && !r_inflight && (w_fill < 2'd2) && !i_flush && !reset;

    // Mode is latched together with the word at capture time.
    always_comb begin
        w_word.s0   = i_fifo_dout[WORD_W-1:SAMPLE_W];
        w_word.s1   = i_fifo_dout[SAMPLE_W-1:0];
        w_word.mode = i_mode;
    end

    // Slot update: retire/shift first, then place the arriving word in the lowest free slot.
    always_comb begin
        w_head_n   = r_head;
        w_head_v_n = r_head_v;
        w_next_n   = r_next;
        w_next_v_n = r_next_v;
        if (i_retire) begin
            w_head_n   = r_next;
            w_head_v_n = r_next_v;
            w_next_v_n = 1'b0;
        end
        if (r_inflight) begin
            if (!w_head_v_n) begin
                w_head_n   = w_word;
                w_head_v_n = 1'b1;
            end else begin
                w_next_n   = w_word;
                w_next_v_n = 1'b1;
            end
        end
        if (i_flush || reset) begin
            w_head_v_n = 1'b0;
            w_next_v_n = 1'b0;
        end
    end

    assign o_head_nxt_c       = w_head_n;
    assign o_head_valid_nxt_c = w_head_v_n;
    assign o_head             = r_head;

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            r_head     <= '0;
            r_next     <= '0;
            r_head_v   <= 1'b0;
            r_next_v   <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_head     <= w_head_n;
            r_next     <= w_next_n;
            r_head_v   <= w_head_v_n;
            r_next_v   <= w_next_v_n;
            r_inflight <= o_rd_en_c;
        end
    end

endmodule

// File: rtl/adc_fifo_byte_unpacker.sv
// Unpacks 24-bit ADC FIFO words (two 12-bit samples) into USB read bytes,
// and keeps the FIFO pop / underflow statistics for the ADC FIFO register block.
module adc_fifo_byte_unpacker import adc_unpack_pkg::*; #(
    parameter int unsigned pCOUNT_W = 32
) (
    input  logic                clk_usb,
    input  logic                reset,
    input  logic [WORD_W-1:0]   fifo_dout,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic                byte_req,
    output logic [BYTE_W-1:0]   byte_data,
    output logic                byte_valid,
    input  logic                low_res,
    input  logic                low_res_lsb,
    input  logic                flush,
    input  logic                clear_counts,
    input  logic                no_underflow_errors,
    output logic [UF_W-1:0]     underflow_count,
    output logic [pCOUNT_W-1:0] fifo_read_count,
    output logic [pCOUNT_W-1:0] fifo_read_count_error_freeze
);

    logic [IDX_W-1:0]    r_idx;
    logic [BYTE_W-1:0]   r_byte_data;
    logic                r_byte_valid;
    logic [UF_W-1:0]     r_uf_count;
    logic [pCOUNT_W-1:0] r_read_count, r_freeze;
    logic                r_frozen;

    slot_t               w_head, w_head_nxt;
    logic                w_head_valid_nxt;
    logic                w_rd_en, w_consume, w_retire, w_underflow;
    logic [IDX_W-1:0]    w_idx_nxt;

    assign w_consume   = byte_req && r_byte_valid;
    assign w_underflow = byte_req && !r_byte_valid;
    assign w_retire    = w_consume && (r_idx == last_idx(w_head.mode));

    adc_word_skid2 u_skid (
        .clk_usb            (clk_usb),
        .reset              (reset),
        .i_flush            (flush),
        .i_fifo_empty       (fifo_empty),
        .i_fifo_dout        (fifo_dout),
        .i_mode             (mode_decode(low_res, low_res_lsb)),
        .i_retire           (w_retire),
        .o_rd_en_c          (w_rd_en),
        .o_head             (w_head),
        .o_head_nxt_c       (w_head_nxt),
        .o_head_valid_nxt_c (w_head_valid_nxt)
    );

    always_comb begin
        w_idx_nxt = r_idx;
        if (flush || w_retire)
            w_idx_nxt = '0;
        else if (w_consume)
            w_idx_nxt = r_idx + IDX_W'(1);
    end

    // Byte output is registered from the next-cycle HEAD so a fresh word shows up without a bubble.
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            r_idx        <= '0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_idx        <= w_idx_nxt;
            r_byte_valid <= w_head_valid_nxt;
            r_byte_data  <= w_head_valid_nxt ? byte_sel(w_head_nxt, w_idx_nxt) : '0;
        end
    end

    // Statistics; clear_counts overrides any same-cycle pop or underflow.
    always_ff @(posedge clk_usb) begin
        if (reset || clear_counts) begin
            r_read_count <= '0;
            r_uf_count   <= '0;
            r_freeze     <= '0;
            r_frozen     <= 1'b0;
        end else begin
            if (w_rd_en)
                r_read_count <= r_read_count + pCOUNT_W'(1);
            if (w_underflow) begin
                if (!no_underflow_errors && (r_uf_count != UF_W'(UF_SAT)))
                    r_uf_count <= r_uf_count + UF_W'(1);
                if (!r_frozen) begin
                    r_freeze <= r_read_count;
                    r_frozen <= 1'b1;
                end
            end
        end
    end

    assign fifo_rd_en                   = w_rd_en;
    assign byte_data                    = r_byte_data;
    assign byte_valid                   = r_byte_valid;
    assign underflow_count              = r_uf_count;
    assign fifo_read_count              = r_read_count;
    assign fifo_read_count_error_freeze = r_freeze;

endmodule

// File: doc/adc_fifo_byte_unpacker.md
# adc_fifo_byte_unpacker

- Sits between the ADC sample FIFO read port and the USB register read mux for ADCREAD_ADDR.
- Pops 24-bit FIFO words, each holding two 12-bit samples, into a 2-entry prefetch buffer.
- Serialises each word into USB bytes: 3 bytes in full-res mode, 2 bytes in low-res mode.
- Generates the FIFO read/underflow statistics consumed by the ADC FIFO register block.

## Interface
Parameters:
- pCOUNT_W, 32, width of the FIFO word-pop counter and its freeze copy.

Ports:
- clk_usb  in  1  USB-domain clock.
- reset  in  1  synchronous, active-high; clock clk_usb.
- fifo_dout  in  24  FIFO read data; sample0 = [23:12], sample1 = [11:0]; valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag, valid in the same cycle.
- fifo_rd_en  out  1  one-cycle FIFO pop.
- byte_req  in  1  one-cycle strobe; the USB side consumed byte_data this cycle.
- byte_data  out  8  current byte, registered.
- byte_valid  out  1  byte_data holds real sample data.
- low_res  in  1  1 = one byte per sample.
- low_res_lsb  in  1  in low-res mode, 1 = sample[7:0], 0 = sample[11:4].
- flush  in  1  discard buffered and in-flight data.
- clear_counts  in  1  clear the counters and the freeze state.
- no_underflow_errors  in  1  1 = underflows do not increment underflow_count.
- underflow_count  out  8  saturating count of byte_req strobes seen while !byte_valid.
- fifo_read_count  out  pCOUNT_W  FIFO pops since the last clear; wraps.
- fifo_read_count_error_freeze  out  pCOUNT_W  fifo_read_count captured at the first underflow since the last clear.

## Operation
- Buffer slots:
  - Two slots, HEAD and NEXT, each with a valid bit and a latched mode (low_res, low_res_lsb).
  - Mode is sampled when a word is captured. A mode change never splits a word.
- Fetch:
  - fifo_rd_en = !fifo_empty && (valid slots + in-flight reads) < 2 && !flush && !reset.
  - At most one read is in flight.
  - The in-flight word is captured the next cycle into HEAD if HEAD is empty, else into NEXT.
- Byte order, full-res:
  - idx0 = s0[11:4]
  - idx1 = {s0[3:0], s1[11:8]}
  - idx2 = s1[7:0]
- Byte order, low-res:
  - idx0 = sel(s0)
  - idx1 = sel(s1)
  - sel = low_res_lsb ? [7:0] : [11:4].
- Consume:
  - byte_req with byte_valid increments idx.
  - On the last index (2 for full-res, 1 for low-res), HEAD is retired and idx returns to 0.
  - NEXT shifts to HEAD in the same edge.
- Underflow: byte_req with !byte_valid:
  - byte_data stays 0x00.
  - underflow_count increments, saturating at 255, unless no_underflow_errors is set.
  - The first such event since the last clear copies fifo_read_count into the freeze register and sets the frozen flag.
  - Later underflows do not update the freeze register.
- fifo_read_count increments on every fifo_rd_en.
- Simultaneous events:
  - Retire of HEAD plus an arriving word with NEXT empty: the word goes to HEAD.
  - Retire of HEAD plus an arriving word with NEXT valid: NEXT moves to HEAD and the word goes to NEXT.
  - clear_counts together with an underflow: clear wins; the counters read 0 the next cycle.
  - clear_counts together with a pop: fifo_read_count = 0.
- Flush and reset mid-operation:
  - Both invalidate both slots, set idx = 0, and drop any in-flight word.
  - A dropped word is still counted in fifo_read_count.
  - flush does not touch the counters.
  - reset clears everything.

## Timing
- Reset values:
  - fifo_rd_en = 0, byte_data = 0x00, byte_valid = 0.
  - underflow_count = 0, fifo_read_count = 0, freeze = 0.
  - Both slots invalid.
- Fill latency from an empty buffer with a non-empty FIFO:
  - rd_en in cycle N.
  - Word captured at the end of N+1.
  - byte_valid and byte_data valid in N+2.
- byte_data and byte_valid are registered; they update the cycle after byte_req.
- Throughput: one byte per cycle back-to-back with no bubble while the FIFO stays non-empty, because the 2-entry prefetch covers the 2-cycle fetch.
- fifo_empty high: no rd_en. The fetch restarts the cycle fifo_empty falls.

## Structure
- Shared package adc_unpack_pkg:
  - mode encoding: FULL, LOW_MSB, LOW_LSB.
  - byte-index constants: LAST_IDX_FULL = 2, LAST_IDX_LOW = 1.
  - sample width: 12.
  - underflow saturation value: 255.
- Sub-module adc_word_skid2: 2-entry word+mode buffer with in-flight tracking.
- The top level holds the byte mux, the index counter and the statistics counters.

## Test plan
- Full-res: FIFO = 0xABC123, byte_req every cycle -> bytes 0xAB, 0xC1, 0x23; byte_valid drops after the third byte.
- Low-res: low_res = 1, low_res_lsb = 1, word 0xABC123 -> 0xBC, 0x23. With low_res_lsb = 0 -> 0xAB, 0x12.
- Back-to-back: 100 words preloaded, continuous byte_req -> 300 bytes with no byte_valid gap after the first; fifo_read_count = 100.
- Underflow: 3 byte_req strobes on an empty buffer after 5 pops -> underflow_count = 3, freeze = 5, byte_data = 0x00.
  - With no_underflow_errors = 1 -> count stays 0.
- Saturation and clear: 300 underflows -> count = 255. clear_counts -> 0 next cycle.
- Flush mid-word (after byte 1 of 3): next valid byte is byte 0 of a newly fetched word; counters unchanged.
- Mode changed mid-word: the current word keeps its mode.
